// File: rtl/exe_mem_skid.sv
// Execute-to-memory pipeline register with a 2-entry skid buffer.
// in_ready_o is decoded from the state register, so a memory stall never reaches execute combinationally.
module exe_mem_skid #(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic [1:0]             occupancy_o
);

  typedef struct packed {
    logic                   we;
    logic [RADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]  wdata;
  } entry_t;

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_n;
  entry_t out_q, out_n;
  entry_t skid_q, skid_n;
  entry_t in_entry;
  logic   accept, issue;

  // x0 is hard-wired zero: never let a write to it through.
  always_comb begin
    in_entry       = '0;
    in_entry.we    = reg_we_i & (reg_waddr_i != '0);
    in_entry.waddr = reg_waddr_i;
    in_entry.wdata = reg_wdata_i;
  end

  assign in_ready_o  = ~rst_i & ~flush_i & (state != FULL);
  assign out_valid_o = (state != EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign issue       = out_valid_o & out_ready_i;

  always_comb begin
    state_n = state;
    out_n   = out_q;
    skid_n  = skid_q;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_n = BUSY;
          out_n   = in_entry;
        end
      end
      BUSY: begin
        if (accept && issue) begin
          out_n = in_entry;
        end else if (accept) begin
          state_n = FULL;
          skid_n  = in_entry;
        end else if (issue) begin
          state_n = EMPTY;
          out_n   = '0;
        end
      end
      FULL: begin
        if (issue) begin
          state_n = BUSY;
          out_n   = skid_q;
          skid_n  = '0;
        end
      end
      default: begin
        state_n = EMPTY;
        out_n   = '0;
        skid_n  = '0;
      end
    endcase
    // Flush discards everything; any same-cycle issue was already taken downstream.
    if (flush_i) begin
      state_n = EMPTY;
      out_n   = '0;
      skid_n  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_n;
      out_q  <= out_n;
      skid_q <= skid_n;
    end
  end

  assign reg_we_o    = out_q.we;
  assign reg_waddr_o = out_q.waddr;
  assign reg_wdata_o = out_q.wdata;
  assign occupancy_o = state;

endmodule

// File: tb/tb_exe_mem_skid.sv
// Scoreboard bench for exe_mem_skid: a queue of accepted entries models the stage,
// the DUT's presented entry and status are compared against it every cycle.
module tb_exe_mem_skid;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready, reg_we;
  logic [AW-1:0] reg_waddr;
  logic [DW-1:0] reg_wdata;
  logic          in_ready, out_valid, we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic [1:0]    occupancy;

  exe_mem_skid #(.DATA_WIDTH(DW), .RADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .reg_we_i(reg_we), .reg_waddr_i(reg_waddr), .reg_wdata_i(reg_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .reg_we_o(we_o), .reg_waddr_o(waddr_o), .reg_wdata_o(wdata_o),
    .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic ready_snap;
  event chk_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compare outputs against the model head, then retire/discard entries.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int sz;
        logic exp_ready;
        sz = exp_q.size();
        exp_ready = !rst && !flush && (sz < 2);
        check("in_ready", in_ready, exp_ready);
        check("occupancy", occupancy, sz);
        check("out_valid", out_valid, sz > 0);
        if (sz > 0) begin
          check("reg_we", we_o, exp_q[0].we);
          check("reg_waddr", waddr_o, exp_q[0].waddr);
          check("reg_wdata", wdata_o, exp_q[0].wdata);
        end else begin
          check("idle_payload", {we_o, waddr_o, wdata_o}, 0);
        end
        if (rst) exp_q.delete();
        else begin
          if (sz > 0 && out_ready) void'(exp_q.pop_front());
          if (flush) exp_q.delete();
        end
        ready_snap = exp_ready;
        ->chk_done;
      end
    end
  end

  // Stimulus side of the scoreboard: record what the stage is expected to deliver.
  initial begin
    forever begin
      @(chk_done);
      if (in_valid && ready_snap) begin
        exp_t e;
        e.we    = reg_we && (reg_waddr != 0);
        e.waddr = reg_waddr;
        e.wdata = reg_wdata;
        exp_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic ordy);
    in_valid  = v;
    reg_we    = we;
    reg_waddr = a;
    reg_wdata = d;
    out_ready = ordy;
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    reg_we = 1'b1; reg_waddr = 5'd3; reg_wdata = 32'h55;
    step(); step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 1);

    // back-to-back stream
    drive(1, 1, 5'd1, 32'h11, 1);
    drive(1, 1, 5'd2, 32'h22, 1);
    drive(1, 1, 5'd3, 32'h33, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // stall into the skid slot, hold, then drain
    drive(1, 1, 5'd5, 32'hA, 0);
    drive(1, 1, 5'd6, 32'hB, 0);
    drive(1, 1, 5'd7, 32'hC, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // write to x0 keeps data but drops the enable
    drive(1, 1, 5'd0, 32'hDEAD, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // flush while full with a same-cycle input
    drive(1, 1, 5'd8, 32'h80, 0);
    drive(1, 1, 5'd9, 32'h90, 0);
    flush = 1'b1;
    drive(1, 1, 5'd10, 32'hF1, 0);
    flush = 1'b0;
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // reset mid-operation with out_ready toggling
    drive(1, 1, 5'd11, 32'h111, 0);
    drive(1, 1, 5'd12, 32'h222, 0);
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 5'd13, 32'h333, 0);
    rst = 1'b1;
    drive(1, 1, 5'd14, 32'h444, 1);
    rst = 1'b0;
    drive(1, 1, 5'd15, 32'h555, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      flush = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 3) == 0 ? 5'd0 : AW'($urandom), $urandom,
            $urandom_range(0, 2) != 0);
    end
    flush = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
